// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 4-stage in-order pipeline (load-use, mispredict redirect, multicycle wait).
// Optional performance counters are enabled by defining HAZARD_CTRL_PERF_EN.
module pipeline_hazard_controller #(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MC_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dec_rs1_addr,
    input  logic [4:0]  dec_rs2_addr,
    input  logic        dec_rs1_used,
    input  logic        dec_rs2_used,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_mispredict,
    input  logic        ex_mc_start,
    input  logic        ex_mc_done,
    input  logic        mem_busy,
    output logic        fetch_stall,
    output logic        fetch_flush,
    output logic        decode_stall,
    output logic        decode_flush,
    output logic        execute_stall,
    output logic        execute_flush,
    output logic        mc_timeout
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN,
        REDIRECT,
        MC_WAIT
    } state_t;

    localparam logic [3:0] RC_LOAD = 4'(REDIRECT_CYCLES - 1);
    localparam logic [7:0] WC_LAST = 8'(MC_TIMEOUT - 1);

    state_t     state, state_nx;
    logic [3:0] rc, rc_nx;
    logic [7:0] wc, wc_nx;
    logic       load_use;

    assign load_use = ex_valid && ex_is_load && (ex_rd_addr != 5'd0) &&
                      ((dec_rs1_used && (dec_rs1_addr == ex_rd_addr)) ||
                       (dec_rs2_used && (dec_rs2_addr == ex_rd_addr)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            rc    <= 4'd0;
            wc    <= 8'd0;
        end else begin
            state <= state_nx;
            rc    <= rc_nx;
            wc    <= wc_nx;
        end
    end

    // Priority: reset, memory back-pressure, then per-state sequencing.
    always_comb begin
        state_nx      = state;
        rc_nx         = rc;
        wc_nx         = wc;
        fetch_stall   = 1'b0;
        fetch_flush   = 1'b0;
        decode_stall  = 1'b0;
        decode_flush  = 1'b0;
        execute_stall = 1'b0;
        execute_flush = 1'b0;
        mc_timeout    = 1'b0;
        if (!rst) begin
            fetch_flush   = 1'b1;
            decode_flush  = 1'b1;
            execute_flush = 1'b1;
        end else if (mem_busy) begin
            fetch_stall   = 1'b1;
            decode_stall  = 1'b1;
            execute_stall = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_mispredict) begin
                        fetch_flush  = 1'b1;
                        decode_flush = 1'b1;
                        if (REDIRECT_CYCLES > 1) begin
                            state_nx = REDIRECT;
                            rc_nx    = RC_LOAD;
                        end
                    end else if (ex_mc_start) begin
                        fetch_stall   = 1'b1;
                        decode_stall  = 1'b1;
                        execute_stall = 1'b1;
                        execute_flush = 1'b1;
                        state_nx      = MC_WAIT;
                        wc_nx         = 8'd0;
                    end else if (load_use) begin
                        fetch_stall  = 1'b1;
                        decode_stall = 1'b1;
                        decode_flush = 1'b1;
                    end
                end
                REDIRECT: begin
                    fetch_flush  = 1'b1;
                    decode_flush = 1'b1;
                    if (ex_mispredict) begin
                        rc_nx = RC_LOAD;
                    end else if (rc <= 4'd1) begin
                        state_nx = RUN;
                        rc_nx    = 4'd0;
                    end else begin
                        rc_nx = rc - 4'd1;
                    end
                end
                MC_WAIT: begin
                    if (ex_mc_done) begin
                        state_nx = RUN;
                        wc_nx    = 8'd0;
                    end else if (wc == WC_LAST) begin
                        mc_timeout = 1'b1;
                        state_nx   = RUN;
                        wc_nx      = 8'd0;
                    end else begin
                        fetch_stall   = 1'b1;
                        decode_stall  = 1'b1;
                        execute_stall = 1'b1;
                        execute_flush = 1'b1;
                        wc_nx         = wc + 8'd1;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic any_stall;
    logic flush_event;

    assign any_stall   = fetch_stall || decode_stall || execute_stall;
    // A flush event is a mispredict acted upon or a load-use bubble; both vanish under mem_busy.
    assign flush_event = rst && !mem_busy &&
                         (((state != MC_WAIT) && ex_mispredict) ||
                          ((state == RUN) && !ex_mispredict && !ex_mc_start && load_use));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_events <= 32'd0;
        end else begin
            if (any_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_event && (perf_flush_events != 32'hFFFF_FFFF))
                perf_flush_events <= perf_flush_events + 32'd1;
        end
    end
`endif

endmodule
